// File: rtl/reg_rename_file.sv
// Architectural register file with ROB-tag rename status and branch checkpoints.
// Reads are combinational with commit bypass; state updates on clk_in when rdy_in is high.
module reg_rename_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned NUM_CKPT = 4,
    localparam int unsigned REG_W   = $clog2(REG_NUM),
    localparam int unsigned CK_W    = $clog2(NUM_CKPT)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic [NUM_SRC*REG_W-1:0]   rs_in,
    output logic [NUM_SRC*XLEN-1:0]    val_out,
    output logic [NUM_SRC-1:0]         busy_out,
    output logic [NUM_SRC*ROB_W-1:0]   tag_out,
    input  logic                       rename_en,
    input  logic [REG_W-1:0]           rename_rd,
    input  logic [ROB_W-1:0]           rename_tag,
    input  logic                       commit_en,
    input  logic [REG_W-1:0]           commit_rd,
    input  logic [ROB_W-1:0]           commit_tag,
    input  logic [XLEN-1:0]            commit_val,
    input  logic                       ckpt_save_en,
    input  logic [CK_W-1:0]            ckpt_save_id,
    input  logic                       ckpt_restore_en,
    input  logic [CK_W-1:0]            ckpt_restore_id,
    input  logic                       flush_en
);

    logic [REG_NUM-1:0][XLEN-1:0]                 val_q;
    logic [REG_NUM-1:0]                           busy_q;
    logic [REG_NUM-1:0][ROB_W-1:0]                tag_q;
    logic [NUM_CKPT-1:0][REG_NUM-1:0]             ck_busy_q;
    logic [NUM_CKPT-1:0][REG_NUM-1:0][ROB_W-1:0]  ck_tag_q;

    logic [REG_NUM-1:0]                           busy_nxt;
    logic [REG_NUM-1:0][ROB_W-1:0]                tag_nxt;
    logic [NUM_CKPT-1:0][REG_NUM-1:0]             ck_busy_nxt;
    logic [NUM_CKPT-1:0][REG_NUM-1:0][ROB_W-1:0]  ck_tag_nxt;
    logic                                         commit_wr;
    logic                                         rename_wr;
    logic                                         save_ok;

    // Next live map and checkpoint contents: flush > restore > rename, commit clears everywhere
    always_comb begin
        commit_wr   = commit_en && (commit_rd != '0);
        rename_wr   = rename_en && (rename_rd != '0);
        save_ok     = ckpt_save_en && !ckpt_restore_en && !flush_en;
        busy_nxt    = busy_q;
        tag_nxt     = tag_q;
        ck_busy_nxt = ck_busy_q;
        ck_tag_nxt  = ck_tag_q;

        if (commit_wr) begin
            for (int s = 0; s < int'(NUM_CKPT); s++) begin
                if (ck_busy_q[s][commit_rd] && (ck_tag_q[s][commit_rd] == commit_tag)) begin
                    ck_busy_nxt[s][commit_rd] = 1'b0;
                end
            end
        end

        if (flush_en) begin
            busy_nxt = '0;
            tag_nxt  = '0;
        end else if (ckpt_restore_en) begin
            busy_nxt = ck_busy_nxt[ckpt_restore_id];
            tag_nxt  = ck_tag_q[ckpt_restore_id];
        end else begin
            if (commit_wr && (tag_q[commit_rd] == commit_tag)) begin
                busy_nxt[commit_rd] = 1'b0;
            end
            if (rename_wr) begin
                busy_nxt[rename_rd] = 1'b1;
                tag_nxt[rename_rd]  = rename_tag;
            end
        end

        // Snapshot sees this cycle's commit and rename
        if (save_ok) begin
            ck_busy_nxt[ckpt_save_id] = busy_nxt;
            ck_tag_nxt[ckpt_save_id]  = tag_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            val_q     <= '0;
            busy_q    <= '0;
            tag_q     <= '0;
            ck_busy_q <= '0;
            ck_tag_q  <= '0;
        end else if (rdy_in) begin
            if (commit_wr) begin
                val_q[commit_rd] <= commit_val;
            end
            busy_q    <= busy_nxt;
            tag_q     <= tag_nxt;
            ck_busy_q <= ck_busy_nxt;
            ck_tag_q  <= ck_tag_nxt;
        end
    end

    // Operand read ports with same-cycle commit bypass; x0 is never written so reads 0
    for (genvar k = 0; k < int'(NUM_SRC); k++) begin : g_rd
        logic [REG_W-1:0] rs;
        logic             hit;
        logic             busy_k;

        assign rs     = rs_in[k*REG_W +: REG_W];
        assign hit    = commit_en && (commit_rd == rs) && (rs != '0);
        assign busy_k = busy_q[rs] && !(hit && (commit_tag == tag_q[rs]));

        assign val_out[k*XLEN +: XLEN]   = hit ? commit_val : val_q[rs];
        assign busy_out[k]               = busy_k;
        assign tag_out[k*ROB_W +: ROB_W] = busy_k ? tag_q[rs] : '0;
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed scenarios with literal expectations plus
// a per-cycle comparison of all read ports against a behavioural map model.
module tb_reg_rename_file;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_NUM  = 32;
    localparam int unsigned ROB_W    = 4;
    localparam int unsigned NUM_SRC  = 2;
    localparam int unsigned NUM_CKPT = 4;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned CK_W     = 2;

    logic                       clk_in = 1'b0;
    logic                       rst_in;
    logic                       rdy_in;
    logic [NUM_SRC*REG_W-1:0]   rs_in;
    logic [NUM_SRC*XLEN-1:0]    val_out;
    logic [NUM_SRC-1:0]         busy_out;
    logic [NUM_SRC*ROB_W-1:0]   tag_out;
    logic                       rename_en;
    logic [REG_W-1:0]           rename_rd;
    logic [ROB_W-1:0]           rename_tag;
    logic                       commit_en;
    logic [REG_W-1:0]           commit_rd;
    logic [ROB_W-1:0]           commit_tag;
    logic [XLEN-1:0]            commit_val;
    logic                       ckpt_save_en;
    logic [CK_W-1:0]            ckpt_save_id;
    logic                       ckpt_restore_en;
    logic [CK_W-1:0]            ckpt_restore_id;
    logic                       flush_en;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    reg_rename_file #(
        .XLEN(XLEN), .REG_NUM(REG_NUM), .ROB_W(ROB_W),
        .NUM_SRC(NUM_SRC), .NUM_CKPT(NUM_CKPT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rs_in(rs_in),
        .val_out(val_out), .busy_out(busy_out), .tag_out(tag_out),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .commit_val(commit_val),
        .ckpt_save_en(ckpt_save_en), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore_en(ckpt_restore_en), .ckpt_restore_id(ckpt_restore_id),
        .flush_en(flush_en)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model: architectural map as plain arrays
    logic [31:0] m_val  [REG_NUM];
    bit          m_busy [REG_NUM];
    int          m_tag  [REG_NUM];
    bit          m_ckb  [NUM_CKPT][REG_NUM];
    int          m_ckt  [NUM_CKPT][REG_NUM];

    always @(posedge clk_in) begin
        int cr;
        int rr;
        bit cw;
        bit rw;
        cr = int'(commit_rd);
        rr = int'(rename_rd);
        cw = commit_en && (cr != 0);
        rw = rename_en && (rr != 0);
        if (rst_in) begin
            started = 1'b1;
            for (int r = 0; r < int'(REG_NUM); r++) begin
                m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
                for (int s = 0; s < int'(NUM_CKPT); s++) begin
                    m_ckb[s][r] = 0; m_ckt[s][r] = 0;
                end
            end
        end else if (rdy_in) begin
            if (cw) begin
                m_val[cr] = commit_val;
                for (int s = 0; s < int'(NUM_CKPT); s++)
                    if (m_ckb[s][cr] && m_ckt[s][cr] == int'(commit_tag)) m_ckb[s][cr] = 0;
            end
            if (flush_en) begin
                for (int r = 0; r < int'(REG_NUM); r++) begin
                    m_busy[r] = 0; m_tag[r] = 0;
                end
            end else if (ckpt_restore_en) begin
                for (int r = 0; r < int'(REG_NUM); r++) begin
                    m_busy[r] = m_ckb[ckpt_restore_id][r];
                    m_tag[r]  = m_ckt[ckpt_restore_id][r];
                end
            end else begin
                if (cw && m_tag[cr] == int'(commit_tag) && !(rw && rr == cr)) m_busy[cr] = 0;
                if (rw) begin
                    m_busy[rr] = 1; m_tag[rr] = int'(rename_tag);
                end
            end
            if (ckpt_save_en && !ckpt_restore_en && !flush_en) begin
                for (int r = 0; r < int'(REG_NUM); r++) begin
                    m_ckb[ckpt_save_id][r] = m_busy[r];
                    m_ckt[ckpt_save_id][r] = m_tag[r];
                end
            end
        end
    end

    // Every cycle: each read port against the model
    always @(negedge clk_in) begin
        if (started) begin
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                int   rs;
                bit   hit;
                logic [31:0] ev;
                bit   eb;
                int   et;
                rs  = int'(rs_in[k*REG_W +: REG_W]);
                hit = commit_en && (int'(commit_rd) == rs) && (rs != 0);
                ev  = hit ? commit_val : m_val[rs];
                eb  = m_busy[rs] && !(hit && int'(commit_tag) == m_tag[rs]);
                et  = eb ? m_tag[rs] : 0;
                checks++;
                if (val_out[k*XLEN +: XLEN] !== ev || busy_out[k] !== eb ||
                    int'(tag_out[k*ROB_W +: ROB_W]) != et) begin
                    failures++;
                    $display("FAIL model_port%0d x%0d: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                             k, rs, val_out[k*XLEN +: XLEN], busy_out[k],
                             tag_out[k*ROB_W +: ROB_W], ev, eb, et);
                end
            end
        end
    end

    function automatic logic [31:0] pv(int k);
        return val_out[k*XLEN +: XLEN];
    endfunction
    function automatic logic [31:0] pb(int k);
        return 32'(busy_out[k]);
    endfunction
    function automatic logic [31:0] pt(int k);
        return 32'(tag_out[k*ROB_W +: ROB_W]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic set_rs(input int a, input int b);
        rs_in = {REG_W'(b), REG_W'(a)};
        #1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        rst_in = 0; rename_en = 0; commit_en = 0;
        ckpt_save_en = 0; ckpt_restore_en = 0; flush_en = 0;
    endtask

    task automatic rename(input int rd, input int tg);
        rename_en = 1; rename_rd = REG_W'(rd); rename_tag = ROB_W'(tg);
    endtask

    task automatic commit(input int rd, input int tg, input logic [31:0] v);
        commit_en = 1; commit_rd = REG_W'(rd); commit_tag = ROB_W'(tg); commit_val = v;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; rs_in = '0;
        rename_en = 0; rename_rd = '0; rename_tag = '0;
        commit_en = 0; commit_rd = '0; commit_tag = '0; commit_val = '0;
        ckpt_save_en = 0; ckpt_save_id = '0; ckpt_restore_en = 0; ckpt_restore_id = '0;
        flush_en = 0;
        @(posedge clk_in);
        tick();

        // Reset state
        set_rs(5, 5);
        chk("rst_val0", pv(0), 0); chk("rst_busy0", pb(0), 0); chk("rst_tag0", pt(0), 0);
        chk("rst_val1", pv(1), 0); chk("rst_busy1", pb(1), 0); chk("rst_tag1", pt(1), 0);

        // Rename then commit with bypass
        rename(5, 3); tick();
        set_rs(5, 5);
        chk("ren_busy", pb(0), 1); chk("ren_tag", pt(0), 3);
        commit(5, 3, 32'hDEAD_BEEF); #1;
        chk("byp_val", pv(0), 32'hDEAD_BEEF); chk("byp_busy", pb(1), 0);
        tick();
        chk("cmt_busy", pb(0), 0); chk("cmt_val", pv(0), 32'hDEAD_BEEF);

        // Stale commit keeps the newer rename
        rename(5, 3); tick();
        rename(5, 7); tick();
        commit(5, 3, 32'h1); tick();
        chk("stale_val", pv(0), 1); chk("stale_busy", pb(0), 1); chk("stale_tag", pt(0), 7);

        // Same-cycle commit and rename of x6
        rename(6, 2); tick();
        commit(6, 2, 32'h55); rename(6, 4); set_rs(6, 6);
        chk("cr_busy_same", pb(0), 0); chk("cr_val_same", pv(0), 32'h55);
        tick();
        chk("cr_busy_next", pb(0), 1); chk("cr_tag_next", pt(0), 4);

        // Checkpoint save / restore
        rename(1, 1); tick();
        ckpt_save_en = 1; ckpt_save_id = 2; tick();
        rename(1, 5); tick();
        rename(2, 6); tick();
        set_rs(1, 2);
        chk("pre_rst_tag1", pt(0), 5); chk("pre_rst_tag2", pt(1), 6);
        ckpt_restore_en = 1; ckpt_restore_id = 2; tick();
        chk("rst_x1_busy", pb(0), 1); chk("rst_x1_tag", pt(0), 1); chk("rst_x2_busy", pb(1), 0);

        // Commit between save and restore scrubs the snapshot
        rename(1, 1); tick();
        ckpt_save_en = 1; ckpt_save_id = 2; tick();
        commit(1, 1, 32'h11); tick();
        rename(1, 5); tick();
        rename(2, 6); tick();
        ckpt_restore_en = 1; ckpt_restore_id = 2; tick();
        set_rs(1, 2);
        chk("scrub_x1_busy", pb(0), 0); chk("scrub_x1_val", pv(0), 32'h11);
        chk("scrub_x2_busy", pb(1), 0);

        // Flush beats rename/restore/save; commit value still lands
        ckpt_save_en = 1; ckpt_save_id = 1; tick();
        rename(3, 9); tick();
        flush_en = 1; rename(3, 2); ckpt_restore_en = 1; ckpt_restore_id = 2;
        ckpt_save_en = 1; ckpt_save_id = 1; commit(4, 0, 32'd9);
        tick();
        set_rs(3, 4);
        chk("fl_x3_busy", pb(0), 0); chk("fl_x3_tag", pt(0), 0);
        chk("fl_x4_val", pv(1), 9); chk("fl_x4_busy", pb(1), 0);
        set_rs(5, 6);
        chk("fl_x5_busy", pb(0), 0); chk("fl_x6_busy", pb(1), 0);
        ckpt_restore_en = 1; ckpt_restore_id = 1; tick();
        chk("slot1_x5_tag", pt(0), 7); chk("slot1_x6_tag", pt(1), 4);

        // x0 is hardwired
        rename(0, 3); commit(0, 0, 32'h123); set_rs(0, 0);
        chk("x0_byp_val", pv(0), 0);
        tick();
        chk("x0_val", pv(0), 0); chk("x0_busy", pb(1), 0);

        // Stall blocks updates
        rdy_in = 0; rename(7, 5); ckpt_restore_en = 1; ckpt_restore_id = 0; tick();
        rdy_in = 1; set_rs(7, 5);
        chk("stall_x7_busy", pb(0), 0); chk("stall_x5_busy", pb(1), 1);

        // Reset overrides a concurrent rename
        rst_in = 1; rename(9, 1); tick();
        set_rs(9, 5);
        chk("rst2_x9_busy", pb(0), 0); chk("rst2_x5_val", pv(1), 0); chk("rst2_x5_busy", pb(1), 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_rename_file.md
# reg_rename_file

Architectural register file plus rename (ROB-tag) status table for the out-of-order core. It is parametrised in register count, data width, ROB tag width and number of source-read ports. It adds branch checkpoints: the rename map can be snapshotted at dispatch and selectively restored on mispredict, instead of only flushed wholesale. It sits between the dispatcher (rename writes, operand reads), the ROB (commit writes) and the CDB/branch unit (flush, restore).

## Interface
Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, architectural registers; REG_W = $clog2(REG_NUM) (derived).
- ROB_W, 4, ROB tag width.
- NUM_SRC, 2, number of operand read ports.
- NUM_CKPT, 4, checkpoint slots; CK_W = $clog2(NUM_CKPT) (derived).

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global stall; low = no state change.
- rs_in  in  NUM_SRC*REG_W  source register index per port (port k at bits [k*REG_W +: REG_W]).
- val_out  out  NUM_SRC*XLEN  source value per port.
- busy_out  out  NUM_SRC  source awaits a ROB result.
- tag_out  out  NUM_SRC*ROB_W  producing ROB tag; 0 when not busy.
- rename_en  in  1  dispatcher allocates a destination.
- rename_rd  in  REG_W  destination register.
- rename_tag  in  ROB_W  ROB entry allocated.
- commit_en  in  1  ROB commits a register write.
- commit_rd  in  REG_W  committed register.
- commit_tag  in  ROB_W  ROB entry committing.
- commit_val  in  XLEN  committed value.
- ckpt_save_en  in  1  snapshot rename map.
- ckpt_save_id  in  CK_W  target slot.
- ckpt_restore_en  in  1  restore map from slot.
- ckpt_restore_id  in  CK_W  source slot.
- flush_en  in  1  full rollback; clears all busy bits.

## Operation
- State: value[REG_NUM], busy[REG_NUM], tag[REG_NUM]. Per checkpoint slot: busy/tag copy.
- Register 0 is hardwired: value 0, never busy. Writes to index 0 (rename or commit) are ignored.
- Read port k is combinational:
  - value = commit_val if commit_en && commit_rd==rs_k && rs_k!=0; otherwise value[rs_k].
  - busy = 0 if the same-cycle commit matches rs_k and commit_tag==tag[rs_k]; otherwise busy[rs_k].
  - tag_out = tag[rs_k] when busy_out=1, else 0.
  - The same-cycle rename is not visible to reads. The instruction being dispatched must not see its own destination.
- Rename (rename_en, rd!=0): busy[rd]<=1, tag[rd]<=rename_tag.
- Commit (commit_en, rd!=0):
  - value[rd]<=commit_val, always.
  - busy[rd]<=0 only if tag[rd]==commit_tag and no same-cycle rename targets rd.
  - In every checkpoint slot whose entry rd has busy=1 and tag==commit_tag, clear that busy bit. Snapshots therefore never reference retired tags.
- Save (ckpt_save_en): slot ckpt_save_id <= the live map after this cycle's commit and rename. Saving overwrites the slot. Slot allocation is owned by the branch unit.
- Restore (ckpt_restore_en): live busy/tag <= the slot contents, with the same-cycle commit clear applied. value[] is untouched. The same-cycle rename is dropped.
- Flush (flush_en): all live busy<=0, tag<=0. Same-cycle rename, save and restore are dropped. The same-cycle commit value write still happens.
- Priority for the live map: flush > restore > rename. Commit value writes happen in every case.
- Save coincident with restore or flush is ignored.
- rdy_in=0: no register or checkpoint update. Reads stay combinational.

## Timing
- Reset (rst_in=1 at edge): all value, busy, tag and checkpoint contents go to 0. With all state 0, val_out, busy_out and tag_out read 0 for every rs_in.
- Read latency: 0 cycles, combinational from rs_in and the commit inputs.
- Rename visible to reads 1 cycle after its edge. Commit visible in the same cycle through bypass.
- Restore or flush takes effect at the edge. The next cycle's reads use the restored or cleared map.
- Reset mid-operation overrides every other input on that edge.
- No handshakes. All inputs are single-cycle qualified by their _en and sampled only when rdy_in=1.

## Test plan
- Reset, then read x5 on both ports -> val_out=0, busy_out=0, tag_out=0.
- Rename x5 tag 3. Next cycle read x5 -> busy=1, tag=3. Commit x5 tag 3 val 0xDEAD_BEEF; same cycle read -> val=0xDEADBEEF, busy=0. Next cycle -> busy=0.
- Rename x5 tag 3, then rename x5 tag 7. Commit x5 tag 3 val 1 -> value[x5]=1, busy stays 1, tag stays 7.
- Same-cycle commit x6 tag 2 and rename x6 tag 4 (x6 previously tag 2) -> busy=1, tag=4. A read of x6 in that cycle -> busy=0 and val=commit_val.
- Checkpoints:
  - Rename x1 tag 1, then save slot 2, then rename x1 tag 5 and x2 tag 6.
  - Restore slot 2 -> x1 busy tag 1, x2 not busy.
  - Repeat with a commit of x1 tag 1 between save and restore -> after restore, x1 not busy.
- Flush concurrent with rename x3 tag 2 and restore -> all busy=0. A concurrent commit of x4 val 9 lands. Rename and commit to x0 -> x0 reads 0, not busy.
